uart_rx_fifo: RTL and testbench
===============================

// Module: uart_rx_fifo
// PURPOSE
//  Parametrised UART receiver: configurable data width, parity, stop bits; 3-sample majority vote;
//  start-glitch rejection; break detection; per-word error flags; show-ahead receive FIFO.
//  Sits between the board RX pin and the core I/O unit. Consumers pop words with a valid/ready handshake.
// PARAMETERS
//  CLK_PER_HALF_BIT  5208  clk cycles per half bit period (bit period = 2*CLK_PER_HALF_BIT); must be >= 4
//  DATA_BITS         8     data bits per frame, 5..9, LSB first
//  PARITY            0     0 none, 1 odd, 2 even
//  STOP_BITS         1     1 or 2
//  FIFO_DEPTH        4     receive FIFO entries, power of two, >= 2
// PORTS
//  clk          in   1                       system clock
//  rstn         in   1                       asynchronous active-low reset
//  rxd          in   1                       serial input, asynchronous to clk, idle high
//  rdata        out  DATA_BITS               FIFO head data
//  rvalid       out  1                       FIFO non-empty; rdata/perr/ferr valid
//  rready       in   1                       consumer pops head when rvalid && rready
//  perr         out  1                       parity error flag of head word (0 when PARITY==0)
//  ferr         out  1                       framing error flag of head word (any stop bit sampled 0)
//  overrun      out  1                       sticky: a word was dropped because the FIFO was full
//  err_clr      in   1                       clears overrun (1-cycle pulse)
//  fifo_count   out  $clog2(FIFO_DEPTH)+1    number of stored words
// BEHAVIOUR
//  Reset (async): rdata=0, rvalid=0, perr=0, ferr=0, overrun=0, fifo_count=0, FSM=IDLE, counters=0,
//   synchroniser preset to 1. Mid-frame reset aborts the frame; nothing is pushed.
//  rxd passes through a 2-FF synchroniser (rxd_s); all decisions use rxd_s.
//  Bit counter: counts 0..2*CLK_PER_HALF_BIT-1 and wraps; cleared on start detection.
//  Majority sample: rxd_s taken at counter = CLK_PER_HALF_BIT-1, CLK_PER_HALF_BIT, CLK_PER_HALF_BIT+1;
//   bit value = majority of the three, resolved in the cycle of the third sample (“sample point”).
//  FSM:
//   IDLE   : rxd_s==0 -> START, counter cleared.
//   START  : at sample point, majority 1 -> IDLE (glitch, nothing pushed); majority 0 -> DATA.
//   DATA   : shift one bit per sample point into bit DATA_BITS-1 (LSB first); after DATA_BITS bits
//            -> PARITY if PARITY!=0 else STOP.
//   PARITY : at sample point, perr_w = (XOR(data)^bit) != (PARITY==1) -> STOP.
//   STOP   : at each sample point ferr_w |= ~bit. After STOP_BITS samples: push word; if data==0,
//            ferr_w==1 and every sampled bit was 0 (break) -> BREAK, else -> IDLE in the same cycle
//            (no wait for stop-bit end; tolerates sender running fast).
//   BREAK  : stay until rxd_s==1, then -> IDLE. No further words pushed during break.
//  Push occurs in the cycle after the final stop sample; rvalid rises the next cycle (latency from final
//   stop sample to rvalid = 2 clk). Each entry stores {perr_w, ferr_w, data}.
//  FIFO: show-ahead; rdata/perr/ferr reflect head whenever rvalid=1, hold last popped value otherwise.
//   Pop when rvalid && rready. Push when full and no pop same cycle -> word dropped, overrun<=1.
//   Push and pop same cycle when full -> both happen, count unchanged, no overrun.
//   Push and pop same cycle when count==1 -> new word becomes head next cycle, rvalid stays 1.
//   Pointers wrap modulo FIFO_DEPTH; fifo_count = push-pop accounting, never exceeds FIFO_DEPTH.
//  overrun: set on drop, cleared by err_clr; drop and err_clr same cycle -> overrun=1 (set wins).
//  perr is constant 0 when PARITY==0.
// TESTING  (CLK_PER_HALF_BIT=8, bit period 16 clk)
//  8N1, send 0xA5, rready=1 -> rvalid pulses 1 cycle, rdata=0xA5, perr=0, ferr=0, fifo_count back to 0.
//  DATA_BITS=7 PARITY=2 STOP_BITS=2, send 0x07 with parity bit 0 -> rdata=0x07, perr=1, ferr=0.
//  rxd low for 4 clk then high -> FSM returns to IDLE, no word pushed; then valid 0x3C frame received.
//  FIFO_DEPTH=4, rready=0, send 0x01..0x05 -> fifo_count=4, overrun=1; drain yields 0x01..0x04 in order;
//   err_clr pulse -> overrun=0.
//  rxd held low for 12 bit periods -> exactly one word rdata=0x00 ferr=1; rxd high then 0x55 -> received OK.
//  rstn asserted mid-DATA of 0x5A -> all outputs 0 immediately; after release, next 0xC3 frame received OK.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   UART receiver feeding a show-ahead receive FIFO. The serial line is
//   brought into the clk domain by a 2-FF synchroniser. Each bit is decided
//   by a 3-sample majority vote around mid-bit. A start bit that does not
//   survive the vote is rejected as a glitch. An all-zero frame followed by
//   a still-low line is a break: one word is stored and nothing more until
//   the line returns high. Every stored word carries its own parity and
//   framing error flags.
//
// Ports
//   clk        system clock
//   rstn       asynchronous active-low reset
//   rxd        serial input, asynchronous to clk, idle high
//   rdata      FIFO head data (holds the last popped value while empty)
//   rvalid     FIFO non-empty; rdata/perr/ferr describe the head word
//   rready     consumer pops the head when rvalid && rready
//   perr       parity error flag of the head word (always 0 without parity)
//   ferr       framing error flag of the head word
//   overrun    sticky: a received word was dropped because the FIFO was full
//   err_clr    one-cycle pulse that clears overrun
//   fifo_count number of stored words
module uart_rx_fifo #(
  parameter int CLK_PER_HALF_BIT = 5208,
  parameter int DATA_BITS        = 8,
  parameter int PARITY           = 0,
  parameter int STOP_BITS        = 1,
  parameter int FIFO_DEPTH       = 4
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          rxd,
  output logic [DATA_BITS-1:0]          rdata,
  output logic                          rvalid,
  input  logic                          rready,
  output logic                          perr,
  output logic                          ferr,
  output logic                          overrun,
  input  logic                          err_clr,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CW = $clog2(2 * CLK_PER_HALF_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int WW = DATA_BITS + 2;

  localparam logic [CW-1:0] CNT_TOP   = CW'(2 * CLK_PER_HALF_BIT - 1);
  localparam logic [CW-1:0] SMP_0     = CW'(CLK_PER_HALF_BIT - 1);
  localparam logic [CW-1:0] SMP_1     = CW'(CLK_PER_HALF_BIT);
  localparam logic [CW-1:0] SMP_2     = CW'(CLK_PER_HALF_BIT + 1);
  localparam logic [3:0]    LAST_BIT  = 4'(DATA_BITS - 1);
  localparam logic          STOP_LAST = (STOP_BITS == 2);
  localparam logic          ODD       = (PARITY == 1);
  localparam logic [AW:0]   DEPTH     = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PAR,
    ST_STOP,
    ST_BRK
  } state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  logic                 rxd_p0, rxd_s;
  logic [CW-1:0]        cnt;
  logic                 smp0_p1, smp1_p1;
  state_t               state, state_n;
  logic [DATA_BITS-1:0] shreg;
  logic [3:0]           bit_cnt;
  logic                 stop_cnt;
  logic                 perr_w, ferr_w, any_one;
  logic                 start_det, samp_pt, maj_bit;
  logic                 ferr_nx, any_nx, last_stop, is_break;

  logic                 vld_p1;
  logic [WW-1:0]        word_p1;

  logic [WW-1:0]        mem [FIFO_DEPTH];
  logic [AW-1:0]        wptr, rptr, rptr_n;
  logic [AW:0]          count, count_n, count_after_pop;
  logic                 full, pop, push, drop;
  logic [WW-1:0]        head_n;
  logic                 perr_q;

  // ---- stage p0: synchroniser and bit timing ----
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rxd_p0 <= 1'b1;
      rxd_s  <= 1'b1;
    end else begin
      rxd_p0 <= rxd;
      rxd_s  <= rxd_p0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt     <= '0;
      smp0_p1 <= 1'b0;
      smp1_p1 <= 1'b0;
    end else begin
      if (start_det || cnt == CNT_TOP) cnt <= '0;
      else                             cnt <= cnt + 1'b1;
      if (cnt == SMP_0) smp0_p1 <= rxd_s;
      if (cnt == SMP_1) smp1_p1 <= rxd_s;
    end
  end

  always_comb begin
    start_det = (state == ST_IDLE) && !rxd_s;
    samp_pt   = (cnt == SMP_2);
    maj_bit   = maj3(smp0_p1, smp1_p1, rxd_s);
    ferr_nx   = ferr_w | ~maj_bit;
    any_nx    = any_one | maj_bit;
    last_stop = (state == ST_STOP) && samp_pt && (stop_cnt == STOP_LAST);
    // A break is a frame of nothing but zeros, parity and stop bits included.
    is_break  = last_stop && (shreg == '0) && ferr_nx && !any_nx;
  end

  // ---- stage p1: frame FSM ----
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:  if (!rxd_s) state_n = ST_START;
      ST_START: if (samp_pt) state_n = maj_bit ? ST_IDLE : ST_DATA;
      ST_DATA:  if (samp_pt && bit_cnt == LAST_BIT)
                  state_n = (PARITY != 0) ? ST_PAR : ST_STOP;
      ST_PAR:   if (samp_pt) state_n = ST_STOP;
      // Leave at the last stop sample rather than the end of the stop bit,
      // so a sender running slightly fast is still tracked.
      ST_STOP:  if (last_stop) state_n = is_break ? ST_BRK : ST_IDLE;
      ST_BRK:   if (rxd_s) state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      perr_w   <= 1'b0;
      ferr_w   <= 1'b0;
      any_one  <= 1'b0;
    end else if (start_det) begin
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      perr_w   <= 1'b0;
      ferr_w   <= 1'b0;
      any_one  <= 1'b0;
    end else if (samp_pt) begin
      case (state)
        ST_DATA: begin
          bit_cnt <= bit_cnt + 1'b1;
          any_one <= any_nx;
        end
        ST_PAR: begin
          perr_w  <= (((^shreg) ^ maj_bit) != ODD);
          any_one <= any_nx;
        end
        ST_STOP: begin
          ferr_w   <= ferr_nx;
          any_one  <= any_nx;
          stop_cnt <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // LSB arrives first, so each new bit enters at the top and shifts down.
  always_ff @(posedge clk) begin
    if (state == ST_DATA && samp_pt) shreg <= {maj_bit, shreg[DATA_BITS-1:1]};
  end

  // ---- stage p2: word handed to the FIFO one cycle after the last stop sample ----
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) vld_p1 <= 1'b0;
    else       vld_p1 <= last_stop;
  end

  always_ff @(posedge clk) begin
    if (last_stop) word_p1 <= {perr_w, ferr_nx, shreg};
  end

  // ---- FIFO ----
  always_comb begin
    full            = (count == DEPTH);
    rvalid          = (count != '0);
    pop             = rvalid && rready;
    push            = vld_p1 && (!full || pop);
    drop            = vld_p1 && full && !pop;
    rptr_n          = rptr + AW'(pop);
    count_after_pop = count - (AW+1)'(pop);
    count_n         = count_after_pop + (AW+1)'(push);
    // When the FIFO drains to empty this cycle, an incoming word goes
    // straight to the head registers instead of waiting a cycle in memory.
    head_n          = (count_after_pop == '0) ? word_p1 : mem[rptr_n];
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= word_p1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      rptr  <= rptr_n;
      count <= count_n;
      if (drop)         overrun <= 1'b1;
      else if (err_clr) overrun <= 1'b0;
    end
  end

  // Registered head: refreshed whenever something remains stored, held otherwise.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdata  <= '0;
      perr_q <= 1'b0;
      ferr   <= 1'b0;
    end else if (count_n != '0) begin
      {perr_q, ferr, rdata} <= head_n;
    end
  end

  assign perr       = (PARITY == 0) ? 1'b0 : perr_q;
  assign fifo_count = count;

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

  localparam int BIT = 16;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn;
  logic       rxd8, rready8, clr8;
  logic [7:0] rdata8;
  logic       rvalid8, perr8, ferr8, ovr8;
  logic [2:0] cnt8;

  logic       rxd7, rready7, clr7;
  logic [6:0] rdata7;
  logic       rvalid7, perr7, ferr7, ovr7;
  logic [2:0] cnt7;

  uart_rx_fifo #(.CLK_PER_HALF_BIT(8), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u8 (
    .clk(clk), .rstn(rstn), .rxd(rxd8), .rdata(rdata8), .rvalid(rvalid8), .rready(rready8),
    .perr(perr8), .ferr(ferr8), .overrun(ovr8), .err_clr(clr8), .fifo_count(cnt8));

  uart_rx_fifo #(.CLK_PER_HALF_BIT(8), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) u7 (
    .clk(clk), .rstn(rstn), .rxd(rxd7), .rdata(rdata7), .rvalid(rvalid7), .rready(rready7),
    .perr(perr7), .ferr(ferr7), .overrun(ovr7), .err_clr(clr7), .fifo_count(cnt7));

  int checks = 0;
  int errors = 0;
  int rv8_cycles = 0;
  logic exp_ovr8 = 1'b0;

  // Expected words, oldest first: {perr, ferr, data[8:0]}.
  logic [10:0] q8[$];
  logic [10:0] q7[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // What the receiver must report for a frame, straight from the line bits.
  function automatic logic [10:0] model_word(input int nbits, input int par, input logic [8:0] data,
                                             input logic pbit, input logic [1:0] stops, input int nstop);
    logic [8:0] d;
    int ones;
    logic pe, fe;
    d    = data & ((9'h1 << nbits) - 9'h1);
    ones = $countones(d) + int'(pbit);
    if (par == 0)      pe = 1'b0;
    else if (par == 1) pe = (ones % 2 == 0);
    else               pe = (ones % 2 == 1);
    fe = !stops[0] || (nstop == 2 && !stops[1]);
    return {pe, fe, d};
  endfunction

  task automatic set_rxd(input int dut, input logic v);
    if (dut == 8) rxd8 = v;
    else          rxd7 = v;
  endtask

  task automatic drive(input int dut, input logic v, input int clks);
    set_rxd(dut, v);
    repeat (clks) @(negedge clk);
  endtask

  task automatic send(input int dut, input logic [8:0] data, input logic pbit, input logic [1:0] stops);
    int nbits, par, nstop;
    logic [10:0] w;
    nbits = (dut == 8) ? 8 : 7;
    par   = (dut == 8) ? 0 : 2;
    nstop = (dut == 8) ? 1 : 2;
    w = model_word(nbits, par, data, pbit, stops, nstop);
    if (dut == 8) begin
      if (q8.size() >= 4) exp_ovr8 = 1'b1;
      else                q8.push_back(w);
    end else begin
      q7.push_back(w);
    end
    drive(dut, 1'b0, BIT);
    for (int i = 0; i < nbits; i++) drive(dut, data[i], BIT);
    if (par != 0) drive(dut, pbit, BIT);
    for (int s = 0; s < nstop; s++) drive(dut, stops[s], BIT);
  endtask

  task automatic wait_valid(input int dut, input string name);
    int n;
    n = 0;
    while (!((dut == 8) ? rvalid8 : rvalid7) && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 400) begin
      errors++;
      $display("FAIL %s: rvalid still 0 after %0d cycles, want 1", name, n);
    end
  endtask

  // Handshake inputs change just after the rising edge so the compare
  // process and the DUT see the same value for the next edge.
  task automatic set_rr(input int dut, input logic v);
    @(posedge clk);
    #1;
    if (dut == 8) rready8 = v;
    else          rready7 = v;
    @(negedge clk);
  endtask

  // Every cycle a head word is presented it must match the oldest expected word.
  always @(negedge clk) begin
    if (rstn) begin
      if (rvalid8) begin
        rv8_cycles++;
        checks++;
        if (q8.size() == 0) begin
          errors++;
          $display("FAIL u8_head: got word 0x%0h, want no word", rdata8);
        end else begin
          if ({perr8, ferr8, 1'b0, rdata8} !== q8[0]) begin
            errors++;
            $display("FAIL u8_head: got 0x%0h, want 0x%0h", {perr8, ferr8, 1'b0, rdata8}, q8[0]);
          end
          if (rready8) void'(q8.pop_front());
        end
      end
      if (rvalid7) begin
        checks++;
        if (q7.size() == 0) begin
          errors++;
          $display("FAIL u7_head: got word 0x%0h, want no word", rdata7);
        end else begin
          if ({perr7, ferr7, 2'b00, rdata7} !== q7[0]) begin
            errors++;
            $display("FAIL u7_head: got 0x%0h, want 0x%0h", {perr7, ferr7, 2'b00, rdata7}, q7[0]);
          end
          if (rready7) void'(q7.pop_front());
        end
      end
      checks++;
      if (cnt8 > 3'd4) begin
        errors++;
        $display("FAIL u8_count_bound: got %0d, want <= 4", cnt8);
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; rxd8 = 1'b1; rxd7 = 1'b1;
    rready8 = 1'b1; rready7 = 1'b0; clr8 = 1'b0; clr7 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rvalid", rvalid8, 0);
    chk("rst_rdata", rdata8, 0);
    chk("rst_count", cnt8, 0);
    chk("rst_overrun", ovr8, 0);
    chk("rst_ferr", ferr8, 0);
    chk("rst_perr", perr8, 0);
    rstn = 1'b1;
    repeat (4) @(negedge clk);

    // 8N1 0xA5 with a ready consumer
    rv8_cycles = 0;
    fork
      send(8, 9'h0A5, 1'b0, 2'b11);
      begin
        wait_valid(8, "a5_wait");
        chk("a5_rdata", rdata8, 8'hA5);
        chk("a5_perr", perr8, 0);
        chk("a5_ferr", ferr8, 0);
      end
    join
    repeat (10) @(negedge clk);
    chk("a5_pulse_len", rv8_cycles, 1);
    chk("a5_count", cnt8, 0);
    chk("a5_hold_rdata", rdata8, 8'hA5);

    // 7E2 0x07 with parity bit 0: even parity violated
    fork
      send(7, 9'h007, 1'b0, 2'b11);
      begin
        wait_valid(7, "p7_wait");
        chk("p7_rdata", rdata7, 7'h07);
        chk("p7_perr", perr7, 1);
        chk("p7_ferr", ferr7, 0);
      end
    join
    set_rr(7, 1'b1);
    set_rr(7, 1'b0);
    repeat (2) @(negedge clk);
    chk("p7_count", cnt7, 0);

    // Start glitch: 4 clk low
    drive(8, 1'b0, 4);
    drive(8, 1'b1, 40);
    chk("glitch_count", cnt8, 0);
    chk("glitch_rvalid", rvalid8, 0);
    fork
      send(8, 9'h03C, 1'b0, 2'b11);
      begin
        wait_valid(8, "3c_wait");
        chk("3c_rdata", rdata8, 8'h3C);
      end
    join
    repeat (4) @(negedge clk);

    // Overrun: five words into a depth-4 FIFO with no consumer
    set_rr(8, 1'b0);
    for (int v = 1; v <= 5; v++) send(8, 9'(v), 1'b0, 2'b11);
    repeat (8) @(negedge clk);
    chk("ovr_count", cnt8, 4);
    chk("ovr_flag", ovr8, 1);
    chk("ovr_flag_model", ovr8, exp_ovr8);
    chk("ovr_head", rdata8, 8'h01);
    set_rr(8, 1'b1);
    for (int n = 0; n < 20 && cnt8 != 3'd0; n++) @(negedge clk);
    chk("drain_count", cnt8, 0);
    chk("drain_last", rdata8, 8'h04);
    chk("ovr_sticky", ovr8, 1);
    @(posedge clk); #1 clr8 = 1'b1;
    @(posedge clk); #1 clr8 = 1'b0;
    @(negedge clk);
    chk("ovr_cleared", ovr8, 0);

    // Break: line low for 12 bit periods
    q8.push_back({1'b0, 1'b1, 9'h000});
    fork
      drive(8, 1'b0, 12 * BIT);
      begin
        wait_valid(8, "brk_wait");
        chk("brk_rdata", rdata8, 8'h00);
        chk("brk_ferr", ferr8, 1);
      end
    join
    drive(8, 1'b1, 2 * BIT);
    chk("brk_count", cnt8, 0);
    fork
      send(8, 9'h055, 1'b0, 2'b11);
      begin
        wait_valid(8, "55_wait");
        chk("55_rdata", rdata8, 8'h55);
        chk("55_ferr", ferr8, 0);
      end
    join
    repeat (4) @(negedge clk);

    // Reset in the middle of 0x5A's data bits
    drive(8, 1'b0, BIT);
    drive(8, 1'b0, BIT);
    drive(8, 1'b1, BIT);
    drive(8, 1'b0, 5);
    rstn = 1'b0;
    #1;
    chk("mid_rst_rdata", rdata8, 0);
    chk("mid_rst_rvalid", rvalid8, 0);
    chk("mid_rst_count", cnt8, 0);
    chk("mid_rst_ferr", ferr8, 0);
    rxd8 = 1'b1;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (4 * BIT) @(negedge clk);
    chk("post_rst_count", cnt8, 0);
    fork
      send(8, 9'h0C3, 1'b0, 2'b11);
      begin
        wait_valid(8, "c3_wait");
        chk("c3_rdata", rdata8, 8'hC3);
        chk("c3_ferr", ferr8, 0);
      end
    join
    repeat (20) @(negedge clk);
    chk("u8_words_left", q8.size(), 0);
    chk("u7_words_left", q7.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
